div_unit: RTL and testbench

Iterative 32-bit signed/unsigned divider for the DIV/DIVU instructions. It sits directly downstream of the execute stage. EXE supplies the operands and a start request, holds its `stallreq` high until `ready_o`, then forwards `result_o` as the {hi, lo} write through the HI/LO path. It computes one quotient bit per cycle (restoring division) and supports abort for flushes.

---
 rtl/div_unit.sv | 138 +++++++++++++
 tb/tb_div_unit.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Iterative restoring divider for DIV/DIVU: one quotient bit per cycle, fixed
// 34-cycle latency, result held as {hi=remainder, lo=quotient} until start drops.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [WIDTH-1:0] VAL_ONE   = WIDTH'(1);

    typedef enum logic [1:0] {
        FREE    = 2'd0,
        BY_ZERO = 2'd1,
        ON      = 2'd2,
        END     = 2'd3
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] dividend_r;
    logic [WIDTH-1:0] divisor_r;
    logic [WIDTH-1:0] rem_r;
    logic             sign1_r;
    logic             sign2_r;

    logic [WIDTH:0]   rem_sh_s;
    logic [WIDTH:0]   trial_s;
    logic [WIDTH-1:0] quo_fix_s;
    logic [WIDTH-1:0] rem_fix_s;

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        return ~v + VAL_ONE;
    endfunction

    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v,
                                                 input logic is_signed);
        if (is_signed && v[WIDTH-1]) begin
            return negate(v);
        end else begin
            return v;
        end
    endfunction

    // Restoring step and final sign correction; the dividend register fills with quotient bits
    always_comb begin
        rem_sh_s  = {rem_r, dividend_r[WIDTH-1]};
        trial_s   = rem_sh_s - {1'b0, divisor_r};
        quo_fix_s = (sign1_r ^ sign2_r) ? negate(dividend_r) : dividend_r;
        rem_fix_s = sign1_r ? negate(rem_r) : rem_r;
    end

    // Divider FSM with registered result and ready
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r    <= FREE;
            cnt_r      <= '0;
            dividend_r <= '0;
            divisor_r  <= '0;
            rem_r      <= '0;
            sign1_r    <= 1'b0;
            sign2_r    <= 1'b0;
            result_o   <= '0;
            ready_o    <= 1'b0;
        end else begin
            case (state_r)
                FREE: begin
                    ready_o  <= 1'b0;
                    result_o <= '0;
                    if (start_i && !annul_i) begin
                        // Sign bits are kept only for DIV so DIVU skips correction
                        dividend_r <= abs_val(opdata1_i, signed_div_i);
                        divisor_r  <= abs_val(opdata2_i, signed_div_i);
                        sign1_r    <= signed_div_i & opdata1_i[WIDTH-1];
                        sign2_r    <= signed_div_i & opdata2_i[WIDTH-1];
                        rem_r      <= '0;
                        cnt_r      <= '0;
                        state_r    <= (opdata2_i == '0) ? BY_ZERO : ON;
                    end else begin
                        state_r <= FREE;
                    end
                end
                BY_ZERO: begin
                    result_o <= '0;
                    ready_o  <= 1'b1;
                    state_r  <= END;
                end
                ON: begin
                    if (annul_i) begin
                        state_r  <= FREE;
                        cnt_r    <= '0;
                        ready_o  <= 1'b0;
                        result_o <= '0;
                    end else if (cnt_r != LAST_STEP) begin
                        // A negative trial keeps the shifted remainder and sets no quotient bit
                        if (!trial_s[WIDTH]) begin
                            rem_r      <= trial_s[WIDTH-1:0];
                            dividend_r <= {dividend_r[WIDTH-2:0], 1'b1};
                        end else begin
                            rem_r      <= rem_sh_s[WIDTH-1:0];
                            dividend_r <= {dividend_r[WIDTH-2:0], 1'b0};
                        end
                        cnt_r <= cnt_r + CNT_ONE;
                    end else begin
                        result_o <= {rem_fix_s, quo_fix_s};
                        ready_o  <= 1'b1;
                        state_r  <= END;
                    end
                end
                END: begin
                    if (!start_i) begin
                        state_r  <= FREE;
                        ready_o  <= 1'b0;
                        result_o <= '0;
                    end else begin
                        state_r <= END;
                    end
                end
                default: begin
                    state_r  <= FREE;
                    ready_o  <= 1'b0;
                    result_o <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus random operands
// compared against a plain-arithmetic division model.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        resetn;
    logic        signed_div;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    div_unit #(.WIDTH(32)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .signed_div_i (signed_div),
        .opdata1_i    (op1),
        .opdata2_i    (op2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready)
    );

    // Reference: 64-bit integer division truncating toward zero, {rem, quo} low 32 bits
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic s);
        longint sa;
        longint sb;
        longint q;
        longint r;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues a start in the current cycle and waits (bounded) for ready; start stays high
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                           output logic [63:0] res, output int lat);
        op1 = a;
        op2 = b;
        signed_div = s;
        start = 1'b1;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!ready && lat < 100);
        res = result;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        start = 1'b0;
        annul = 1'b0;
        signed_div = 1'b0;
        op1 = 32'd0;
        op2 = 32'd0;
        repeat (3) tick();
        checks++;
        if (ready !== 1'b0 || result !== 64'd0) begin
            errors++;
            $display("FAIL reset_state: ready=%b result=%h expected ready=0 result=0", ready, result);
        end
        resetn = 1'b1;
        tick();
        checks++;
        if (ready !== 1'b0 || result !== 64'd0) begin
            errors++;
            $display("FAIL idle_state: ready=%b result=%h expected ready=0 result=0", ready, result);
        end
    endtask

    task automatic test_unsigned_hold();
        logic [63:0] res;
        int lat;
        run_div(32'hFFFFFFFF, 32'h00000010, 1'b0, res, lat);
        checks++;
        if (lat !== 34) begin
            errors++;
            $display("FAIL udiv_latency: got %0d expected 34", lat);
        end
        checks++;
        if (res !== 64'h0000000F_0FFFFFFF) begin
            errors++;
            $display("FAIL udiv_result: got %h expected %h", res, 64'h0000000F_0FFFFFFF);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (ready !== 1'b1 || result !== 64'h0000000F_0FFFFFFF) begin
                errors++;
                $display("FAIL udiv_hold: cycle %0d ready=%b result=%h expected ready=1 result=%h",
                         i, ready, result, 64'h0000000F_0FFFFFFF);
            end
        end
        start = 1'b0;
        tick();
        checks++;
        if (ready !== 1'b0 || result !== 64'd0) begin
            errors++;
            $display("FAIL udiv_release: ready=%b result=%h expected ready=0 result=0", ready, result);
        end
    endtask

    task automatic test_signed();
        logic [31:0] a_tab [3] = '{32'hFFFFFFF9, 32'h00000007, 32'h80000000};
        logic [31:0] b_tab [3] = '{32'h00000002, 32'hFFFFFFFE, 32'hFFFFFFFF};
        logic [63:0] e_tab [3] = '{64'hFFFFFFFF_FFFFFFFD, 64'h00000001_FFFFFFFD,
                                   64'h00000000_80000000};
        logic [63:0] res;
        int lat;
        for (int i = 0; i < 3; i++) begin
            run_div(a_tab[i], b_tab[i], 1'b1, res, lat);
            checks++;
            if (res !== e_tab[i] || lat !== 34) begin
                errors++;
                $display("FAIL signed_div%0d: got %h lat %0d expected %h lat 34",
                         i, res, lat, e_tab[i]);
            end
            start = 1'b0;
            tick();
        end
    endtask

    task automatic test_div_zero();
        logic [63:0] res;
        int lat;
        for (int s = 0; s < 2; s++) begin
            run_div(32'h12345678, 32'h0, s[0], res, lat);
            checks++;
            if (res !== 64'd0 || lat !== 2) begin
                errors++;
                $display("FAIL div_zero_s%0d: got %h lat %0d expected 0 lat 2", s, res, lat);
            end
            start = 1'b0;
            tick();
        end
    endtask

    task automatic test_annul();
        logic [63:0] res;
        int lat;
        int pulses;
        op1 = 32'd100;
        op2 = 32'd7;
        signed_div = 1'b0;
        start = 1'b1;
        repeat (10) tick();
        annul = 1'b1;
        tick();
        checks++;
        if (ready !== 1'b0 || result !== 64'd0) begin
            errors++;
            $display("FAIL annul_abort: ready=%b result=%h expected ready=0 result=0", ready, result);
        end
        annul = 1'b0;
        start = 1'b0;
        pulses = 0;
        repeat (40) begin
            tick();
            if (ready) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL annul_no_ready: got %0d ready cycles expected 0", pulses);
        end
        run_div(32'd100, 32'd7, 1'b0, res, lat);
        checks++;
        if (res !== 64'h00000002_0000000E || lat !== 34) begin
            errors++;
            $display("FAIL annul_restart: got %h lat %0d expected %h lat 34",
                     res, lat, 64'h00000002_0000000E);
        end
        start = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        logic [63:0] res;
        int lat;
        op1 = 32'd1000;
        op2 = 32'd3;
        signed_div = 1'b0;
        start = 1'b1;
        repeat (20) tick();
        resetn = 1'b0;
        start = 1'b0;
        tick();
        checks++;
        if (ready !== 1'b0 || result !== 64'd0) begin
            errors++;
            $display("FAIL reset_mid: ready=%b result=%h expected ready=0 result=0", ready, result);
        end
        resetn = 1'b1;
        tick();
        run_div(32'd1000, 32'd3, 1'b0, res, lat);
        checks++;
        if (res !== ref_div(32'd1000, 32'd3, 1'b0) || lat !== 34) begin
            errors++;
            $display("FAIL reset_recover: got %h lat %0d expected %h lat 34",
                     res, lat, ref_div(32'd1000, 32'd3, 1'b0));
        end
        start = 1'b0;
        tick();
    endtask

    task automatic test_operand_change();
        logic [63:0] exp;
        int lat;
        exp = ref_div(32'hDEADBEEF, 32'h00001234, 1'b1);
        op1 = 32'hDEADBEEF;
        op2 = 32'h00001234;
        signed_div = 1'b1;
        start = 1'b1;
        lat = 0;
        do begin
            tick();
            lat++;
            op1 = $urandom;
            op2 = $urandom;
            signed_div = 1'($urandom_range(0, 1));
        end while (!ready && lat < 100);
        checks++;
        if (result !== exp || lat !== 34) begin
            errors++;
            $display("FAIL operand_change: got %h lat %0d expected %h lat 34", result, lat, exp);
        end
        start = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [63:0] res;
        int lat;
        run_div(32'd50, 32'd6, 1'b0, res, lat);
        tick();
        checks++;
        if (ready !== 1'b1 || result !== ref_div(32'd50, 32'd6, 1'b0)) begin
            errors++;
            $display("FAIL b2b_first_hold: ready=%b result=%h expected ready=1 result=%h",
                     ready, result, ref_div(32'd50, 32'd6, 1'b0));
        end
        start = 1'b0;
        tick();
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap: ready=%b expected 0", ready);
        end
        run_div(32'd9, 32'd3, 1'b0, res, lat);
        checks++;
        if (res !== 64'h00000000_00000003 || lat !== 34) begin
            errors++;
            $display("FAIL b2b_second: got %h lat %0d expected %h lat 34",
                     res, lat, 64'h00000000_00000003);
        end
        start = 1'b0;
        tick();
    endtask

    task automatic test_random();
        logic [63:0] res;
        logic [31:0] a;
        logic [31:0] b;
        logic s;
        int lat;
        int exp_lat;
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            if (i % 7 == 0) b = 32'd0;
            else if (i % 3 == 0) b = $urandom_range(1, 15);
            else if (i % 5 == 0) b = 32'hFFFFFFFF;
            else b = $urandom;
            s = 1'($urandom_range(0, 1));
            exp_lat = (b == 32'd0) ? 2 : 34;
            run_div(a, b, s, res, lat);
            checks++;
            if (res !== ref_div(a, b, s) || lat !== exp_lat) begin
                errors++;
                $display("FAIL random%0d: %h/%h s=%b got %h lat %0d expected %h lat %0d",
                         i, a, b, s, res, lat, ref_div(a, b, s), exp_lat);
            end
            start = 1'b0;
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_unsigned_hold();
        test_signed();
        test_div_zero();
        test_annul();
        test_reset_mid();
        test_operand_change();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
